// File: rtl/music_pkg.sv
// Shared music-player definitions: note-timer state encoding and the common duration width.
package music_pkg;

   localparam int DW = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } note_state_e;

endpackage

// File: rtl/note_timer_if.sv
// Note-timer control/status bundle; the player sequencer is the master, the timer the slave.
interface note_timer_if
   import music_pkg::*;
#(
   parameter int DW = music_pkg::DW
);

   logic          load;
   logic [DW-1:0] duration;
   logic          pause;
   logic          done;
   logic          busy;
   logic          paused;
   logic          beat;
   logic [DW-1:0] remaining;

   modport master (
      output load, duration, pause,
      input  done, busy, paused, beat, remaining
   );

   modport slave (
      input  load, duration, pause,
      output done, busy, paused, beat, remaining
   );

endinterface

// File: rtl/beat_prescaler.sv
// Mod-BEAT_DIV clock-cycle counter; tick marks the last enabled cycle of each beat unit.
module beat_prescaler #(
   parameter int BEAT_DIV = 4,
   parameter int PW       = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam logic [PW-1:0] LAST = PW'(BEAT_DIV - 1);

   logic [PW-1:0] count_q;
   logic [PW-1:0] count_d;
   logic          count_we;

   always_comb begin
      tick     = en && (count_q == LAST);
      count_we = clr || en;
      count_d  = count_q + PW'(1);
      if (clr || tick) begin
         count_d = '0;
      end
   end

   dffre #(.W(PW)) u_count (
      .clk   (clk),
      .reset (reset),
      .en    (count_we),
      .d     (count_d),
      .q     (count_q)
   );

endmodule

// File: rtl/dffre.sv
// Generic register cell: synchronous active-high reset to zero, write enable.
module dffre #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/note_timer.sv
// Per-note countdown timer: loads a duration, counts beats while running, holds done until the next load.
module note_timer
   import music_pkg::*;
#(
   parameter int DW       = music_pkg::DW,
   parameter int BEAT_DIV = 4,
   parameter int PW       = 16
) (
   input  logic         clk,
   input  logic         reset,
   note_timer_if.slave  bus
);

   note_state_e   state_q, state_d;
   logic [DW-1:0] remaining_q, remaining_d;
   logic          beat_q, beat_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;
   logic          paused_q, paused_d;
   logic          count_en;
   logic          tick;

   assign count_en = (state_q == RUN) && !bus.pause && !bus.load;

   beat_prescaler #(
      .BEAT_DIV (BEAT_DIV),
      .PW       (PW)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clr   (bus.load),
      .en    (count_en),
      .tick  (tick)
   );

   // Load overrides everything; the status flags are registered decodes of the next state.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      beat_d      = 1'b0;
      if (bus.load) begin
         remaining_d = bus.duration;
         state_d     = (bus.duration == '0) ? DONE : RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (bus.pause) begin
                  state_d = HOLD;
               end else if (tick && (remaining_q != '0)) begin
                  remaining_d = remaining_q - DW'(1);
                  beat_d      = 1'b1;
                  if (remaining_q == DW'(1)) begin
                     state_d = DONE;
                  end
               end
            end
            HOLD: begin
               if (!bus.pause) begin
                  state_d = RUN;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
      done_d   = (state_d == DONE);
      busy_d   = (state_d == RUN) || (state_d == HOLD);
      paused_d = (state_d == HOLD);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         beat_q      <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         paused_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         beat_q      <= beat_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         paused_q    <= paused_d;
      end
   end

   assign bus.done      = done_q;
   assign bus.busy      = busy_q;
   assign bus.paused    = paused_q;
   assign bus.beat      = beat_q;
   assign bus.remaining = remaining_q;

endmodule

// File: tb/tb_note_timer.sv
// Scenario bench for note_timer at BEAT_DIV=4; expected per-cycle outputs are queued from the timeline.
module tb_note_timer;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   logic [9:0] sb[$];
   logic [9:0] exp_v;
   logic [9:0] obs_v;

   note_timer_if #(.DW(6)) bus ();

   note_timer #(
      .DW       (6),
      .BEAT_DIV (4),
      .PW       (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Expected output word: {done, busy, paused, beat, remaining}.
   function automatic logic [9:0] mk(logic d, logic b, logic p, logic bt, int rem);
      logic [5:0] r;
      r = 6'(rem);
      return {d, b, p, bt, r};
   endfunction

   task automatic do_reset();
      reset    = 1'b1;
      bus.load = 1'b0;
      bus.pause = 1'b0;
      bus.duration = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.load = 1'b0;
      bus.pause = 1'b0;
      bus.duration = 6'd5;
      for (int c = 1; c <= 10; c++) sb.push_back(mk(0, 0, 0, 0, 0));
      for (int c = 0; c <= 10; c++) begin
         if (c > 0) begin
            exp_v = sb.pop_front();
            obs_v = {bus.done, bus.busy, bus.paused, bus.beat, bus.remaining};
            checks++;
            if (obs_v !== exp_v) begin
               failures++;
               $display("[TB] FAIL reset cycle=%0d got=%b required=%b", c, obs_v, exp_v);
            end
         end
         reset = (c < 2);
         @(negedge clk);
      end
   endtask

   task automatic test_duration3();
      do_reset();
      for (int c = 1; c <= 16; c++) begin
         int rem;
         rem = (c < 5) ? 3 : (c < 9) ? 2 : (c < 13) ? 1 : 0;
         sb.push_back(mk(c >= 13, c < 13, 0, (c == 5) || (c == 9) || (c == 13), rem));
      end
      for (int c = 0; c <= 16; c++) begin
         if (c > 0) begin
            exp_v = sb.pop_front();
            obs_v = {bus.done, bus.busy, bus.paused, bus.beat, bus.remaining};
            checks++;
            if (obs_v !== exp_v) begin
               failures++;
               $display("[TB] FAIL duration3 cycle=%0d got=%b required=%b", c, obs_v, exp_v);
            end
         end
         bus.load     = (c == 0);
         bus.duration = 6'd3;
         @(negedge clk);
      end
   endtask

   task automatic test_zero_length();
      do_reset();
      for (int c = 1; c <= 6; c++) sb.push_back(mk(1, 0, 0, 0, 0));
      for (int c = 0; c <= 6; c++) begin
         if (c > 0) begin
            exp_v = sb.pop_front();
            obs_v = {bus.done, bus.busy, bus.paused, bus.beat, bus.remaining};
            checks++;
            if (obs_v !== exp_v) begin
               failures++;
               $display("[TB] FAIL zero_length cycle=%0d got=%b required=%b", c, obs_v, exp_v);
            end
         end
         bus.load     = (c == 0);
         bus.duration = 6'd0;
         bus.pause    = (c >= 2) && (c <= 4);
         @(negedge clk);
      end
      bus.pause = 1'b0;
   endtask

   task automatic test_pause();
      do_reset();
      for (int c = 1; c <= 22; c++) begin
         int rem;
         rem = (c < 5) ? 3 : (c < 15) ? 2 : (c < 19) ? 1 : 0;
         sb.push_back(mk(c >= 19, c < 19, (c >= 7) && (c <= 11),
                         (c == 5) || (c == 15) || (c == 19), rem));
      end
      for (int c = 0; c <= 22; c++) begin
         if (c > 0) begin
            exp_v = sb.pop_front();
            obs_v = {bus.done, bus.busy, bus.paused, bus.beat, bus.remaining};
            checks++;
            if (obs_v !== exp_v) begin
               failures++;
               $display("[TB] FAIL pause cycle=%0d got=%b required=%b", c, obs_v, exp_v);
            end
         end
         bus.load     = (c == 0);
         bus.duration = 6'd3;
         bus.pause    = (c >= 6) && (c <= 10);
         @(negedge clk);
      end
      bus.pause = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int c = 1; c <= 16; c++) begin
         if (c <= 4)       sb.push_back(mk(0, 1, 0, 0, 3));
         else if (c == 5)  sb.push_back(mk(0, 1, 0, 1, 2));
         else if (c <= 7)  sb.push_back(mk(0, 1, 0, 0, 2));
         else if (c <= 11) sb.push_back(mk(0, 1, 0, 0, 1));
         else if (c == 12) sb.push_back(mk(1, 0, 0, 1, 0));
         else if (c <= 14) sb.push_back(mk(1, 0, 0, 0, 0));
         else              sb.push_back(mk(0, 1, 0, 0, 2));
      end
      for (int c = 0; c <= 16; c++) begin
         if (c > 0) begin
            exp_v = sb.pop_front();
            obs_v = {bus.done, bus.busy, bus.paused, bus.beat, bus.remaining};
            checks++;
            if (obs_v !== exp_v) begin
               failures++;
               $display("[TB] FAIL back_to_back cycle=%0d got=%b required=%b", c, obs_v, exp_v);
            end
         end
         bus.load     = (c == 0) || (c == 7) || (c == 14);
         bus.duration = (c == 7) ? 6'd1 : (c == 14) ? 6'd2 : 6'd3;
         @(negedge clk);
      end
   endtask

   task automatic test_load_pause();
      do_reset();
      for (int c = 1; c <= 14; c++) begin
         if (c == 1)       sb.push_back(mk(0, 1, 0, 0, 2));
         else if (c <= 4)  sb.push_back(mk(0, 1, 1, 0, 2));
         else if (c <= 8)  sb.push_back(mk(0, 1, 0, 0, 2));
         else if (c == 9)  sb.push_back(mk(0, 1, 0, 1, 1));
         else if (c <= 12) sb.push_back(mk(0, 1, 0, 0, 1));
         else if (c == 13) sb.push_back(mk(1, 0, 0, 1, 0));
         else              sb.push_back(mk(1, 0, 0, 0, 0));
      end
      for (int c = 0; c <= 14; c++) begin
         if (c > 0) begin
            exp_v = sb.pop_front();
            obs_v = {bus.done, bus.busy, bus.paused, bus.beat, bus.remaining};
            checks++;
            if (obs_v !== exp_v) begin
               failures++;
               $display("[TB] FAIL load_pause cycle=%0d got=%b required=%b", c, obs_v, exp_v);
            end
         end
         bus.load     = (c == 0);
         bus.duration = 6'd2;
         bus.pause    = (c <= 3);
         @(negedge clk);
      end
      bus.pause = 1'b0;
   endtask

   task automatic test_reset_mid_note();
      do_reset();
      for (int c = 1; c <= 20; c++) begin
         if (c <= 4)      sb.push_back(mk(0, 1, 0, 0, 3));
         else if (c == 5) sb.push_back(mk(0, 1, 0, 1, 2));
         else if (c == 6) sb.push_back(mk(0, 1, 0, 0, 2));
         else             sb.push_back(mk(0, 0, 0, 0, 0));
      end
      for (int c = 0; c <= 20; c++) begin
         if (c > 0) begin
            exp_v = sb.pop_front();
            obs_v = {bus.done, bus.busy, bus.paused, bus.beat, bus.remaining};
            checks++;
            if (obs_v !== exp_v) begin
               failures++;
               $display("[TB] FAIL reset_mid_note cycle=%0d got=%b required=%b", c, obs_v, exp_v);
            end
         end
         bus.load     = (c == 0);
         bus.duration = 6'd3;
         reset        = (c == 6);
         @(negedge clk);
      end
   endtask

   initial begin
      reset        = 1'b1;
      bus.load     = 1'b0;
      bus.pause    = 1'b0;
      bus.duration = '0;
      @(negedge clk);
      $display("[TB] note_timer scenarios start");
      test_reset();
      test_duration3();
      test_zero_length();
      test_pause();
      test_back_to_back();
      test_load_pause();
      test_reset_mid_note();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/note_timer.md
Name: note_timer

Overview:
- Per-note duration timer for the music-player datapath. It sits directly upstream of the note-end detector.
- It loads a note's 6-bit duration, counts down one unit per beat, and drives a level `done` that stays high once the note has expired.
- The end detector turns the rising edge of `done` into a one-cycle "advance to next note" pulse.
- Supports pause, restart-on-load and zero-length notes.

Parameters:
- DW, 6, width of duration and remaining.
- BEAT_DIV, 4, clk cycles per beat unit. Legal range ≥1. Use 4 in simulation; set per board clock in the top level.
- PW, 16, prescaler counter width. Must satisfy 2^PW ≥ BEAT_DIV.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  one-cycle request to start a new note using `duration`.
- duration  input  DW  note length in beats; sampled only when load=1.
- pause  input  1  level; freezes counting while high.
- done  output  1  registered level; high from note expiry until the next load or reset. Connects to the end detector's `in`.
- busy  output  1  registered; high in RUN or HOLD.
- paused  output  1  registered; high in HOLD.
- beat  output  1  registered one-cycle pulse per completed beat unit.
- remaining  output  DW  registered; beats left in the current note.

Behaviour:
- One clock: clk. Reset is synchronous and active-high.
- Reset (highest priority): state=IDLE, prescaler=0, remaining=0, done=0, busy=0, paused=0, beat=0.
- States and outputs:
  - IDLE: all outputs low.
  - RUN: busy=1.
  - HOLD: busy=1, paused=1.
  - DONE: done=1.
- load=1, in any state (priority over pause):
  - remaining<=duration, prescaler<=0, beat<=0.
  - If duration==0, next state is DONE, so done is high the cycle after load.
  - Otherwise next state is RUN, so done drops the cycle after load.
- Counting happens only when state==RUN, pause=0 and load=0.
  - Each such cycle, prescaler increments.
  - When prescaler==BEAT_DIV-1, it forms a tick: prescaler<=0, remaining<=remaining-1, beat<=1 for one cycle.
  - If remaining==1 at the tick, next state is DONE. remaining=0, done=1 and beat=1 all appear in the same cycle.
- Pause handling:
  - RUN with pause=1: next state HOLD, no count that cycle.
  - HOLD with pause=1: stay in HOLD; prescaler and remaining frozen.
  - HOLD with pause=0: next state RUN, no count that cycle.
  - Net effect: pause high for k cycles during RUN delays done by k+1 cycles.
- Pause outside RUN/HOLD: ignored in IDLE and DONE.
- DONE is held until load or reset. pause has no effect in DONE.
- Latency: with load high in cycle 0 and D≥1, done first goes high in cycle D*BEAT_DIV+1. Beat pulses occur in cycles n*BEAT_DIV+1 for n=1..D.
- Width rules:
  - remaining is unsigned and never decrements below 0; a tick cannot occur when remaining==0.
  - prescaler compares against BEAT_DIV-1 truncated to PW bits.
  - BEAT_DIV=1 means one tick per RUN cycle.
- Reset mid-note returns to IDLE in the next cycle with all outputs 0. No residual beat or done.
- load during RUN or HOLD restarts the note: partial prescaler is discarded and paused clears.

Decomposition:
- Shared package music_pkg:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, HOLD=2'd2, DONE=2'd3.
  - DW=6 constant, shared with the note ROM and the end detector.
- One sub-module, beat_prescaler:
  - ports: clk, reset, clr, en, tick.
  - mod-BEAT_DIV counter built on the existing dffre register cell.
  - tick is combinational and equals en && (count==BEAT_DIV-1).
- The FSM and remaining register live in note_timer.

Test Plan (BEAT_DIV=4):
- Reset held 2 cycles, then released with no load → done=0, busy=0, remaining=0, beat never pulses.
- load with duration=3 in cycle 0 → busy=1 from cycle 1; beat pulses in cycles 5, 9 and 13; remaining steps 3→2→1→0 in cycles 5, 9 and 13; done=1 from cycle 13 and held.
- load with duration=0 → done=1 in cycle 1, busy=0, no beat pulses.
- duration=3, pause high in cycles 6–10 (k=5) → paused=1 in cycles 7–11; remaining frozen at 2; done rises in cycle 19.
- duration=3, load with duration=1 at cycle 7 → remaining=1 in cycle 8, done rises in cycle 12. Separately, load with duration=2 while in DONE → done=0 the next cycle.
- load and pause asserted together with duration=2 → load wins, state is RUN next cycle and pause then moves it to HOLD. Separately, reset asserted in cycle 6 of a duration-3 note → all outputs 0 from cycle 7, with no done pulse afterwards.
